lenet_result_voter: RTL and testbench

LENET_RESULT_VOTER -- requirements
Module: lenet_result_voter

---
 rtl/lenet_pkg.sv | 14 +
 rtl/rise_edge_det.sv | 30 +++
 rtl/lenet_result_voter.sv | 192 +++++++++++++++++++
 tb/tb_lenet_result_voter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: class count, digit width and the vote FSM
// state encoding. Also used by lenet_control and the VGA overlay.
package lenet_pkg;

  localparam int LENET_NUM_CLASSES = 10;
  localparam int LENET_DIGIT_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } vote_state_t;

endpackage

// File: rtl/rise_edge_det.sv
// 1-bit registered rising-edge detector.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : level input
//   rise       : high in the cycle where din=1 and its registered copy is 0
// RESET_VAL sets the registered copy during reset; a value of 1 keeps a
// level that is already high at reset release from looking like an edge.
module rise_edge_det #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_d;

  // One-cycle delayed copy of the input level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_d <= RESET_VAL;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;

endmodule

// File: rtl/lenet_result_voter.sv
// Majority voter over the most recent LeNet digit results. Each new
// result enters a short history; a scan over all classes finds the most
// frequent digit and publishes it when it has at least MIN_VOTES hits.
// Ports:
//   clk, rst_n   : LeNet clock, asynchronous active-low reset
//   enable       : inference mode; low flushes history and invalidates output
//   lenet_ready  : LeNet done level, a rising edge delivers a result
//   lenet_digit  : result digit, sampled in the edge cycle
//   stable_digit : published digit for the VGA overlay
//   stable_valid : stable_digit is meaningful
//   votes        : occurrence count of the published digit
//   busy         : vote FSM is scanning or deciding
module lenet_result_voter
  import lenet_pkg::*;
#(
  parameter int HIST_DEPTH  = 5,
  parameter int NUM_CLASSES = LENET_NUM_CLASSES,
  parameter int MIN_VOTES   = 3,
  parameter int DIGIT_W     = LENET_DIGIT_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              lenet_ready,
  input  logic [DIGIT_W-1:0]                lenet_digit,
  output logic [DIGIT_W-1:0]                stable_digit,
  output logic                              stable_valid,
  output logic [$clog2(HIST_DEPTH+1)-1:0]   votes,
  output logic                              busy
);

  localparam int CNT_W = $clog2(HIST_DEPTH + 1);
  localparam logic [DIGIT_W:0]   CLASS_LIMIT = (DIGIT_W + 1)'(NUM_CLASSES);
  localparam logic [DIGIT_W-1:0] LAST_CLASS  = DIGIT_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0]   DEPTH_MAX   = CNT_W'(HIST_DEPTH);
  localparam logic [CNT_W-1:0]   VOTE_MIN    = CNT_W'(MIN_VOTES);

  vote_state_t state;
  vote_state_t state_next;

  logic               ready_rise;
  logic               digit_ok;
  logic               new_result;
  logic               apply_now;
  logic               to_pending;
  logic [DIGIT_W-1:0] apply_digit;
  logic               scan_req;
  logic               scan_last;

  logic [DIGIT_W-1:0] history [HIST_DEPTH];
  logic [CNT_W-1:0]   fill;
  logic               pend_valid;
  logic [DIGIT_W-1:0] pend_digit;

  logic [DIGIT_W-1:0] scan_idx;
  logic [DIGIT_W-1:0] best_class;
  logic [CNT_W-1:0]   best_count;
  logic [CNT_W-1:0]   slot_count;

  rise_edge_det #(
    .RESET_VAL (1'b1)
  ) u_ready_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (lenet_ready),
    .rise  (ready_rise)
  );

  // Out-of-range digits are discarded before they can touch any state.
  // The extra MSB lets NUM_CLASSES equal 2**DIGIT_W.
  assign digit_ok   = ({1'b0, lenet_digit} < CLASS_LIMIT);
  assign new_result = ready_rise & enable & digit_ok;

  // History only moves in a plain IDLE cycle. A parked result takes
  // priority; a result arriving in that same cycle is parked in its place.
  assign apply_now   = (state == IDLE) && !scan_req && (pend_valid || new_result);
  assign apply_digit = pend_valid ? pend_digit : lenet_digit;
  assign to_pending  = new_result && !(apply_now && !pend_valid);

  assign scan_last = (scan_idx == LAST_CLASS);
  assign busy      = (state != IDLE);

  // Number of filled history slots holding the class under scan
  always_comb begin
    slot_count = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if ((CNT_W'(i) < fill) && (history[i] == scan_idx)) begin
        slot_count = slot_count + 1'b1;
      end
    end
  end

  // Vote FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Vote FSM next state; the scan starts one cycle after a history update
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (scan_req) state_next = SCAN;
        SCAN:    if (scan_last) state_next = DECIDE;
        DECIDE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // History shift register, fill count and scan request flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIST_DEPTH; i++) history[i] <= '0;
      fill     <= '0;
      scan_req <= 1'b0;
    end else if (!enable) begin
      for (int i = 0; i < HIST_DEPTH; i++) history[i] <= '0;
      fill     <= '0;
      scan_req <= 1'b0;
    end else begin
      scan_req <= apply_now;
      if (apply_now) begin
        for (int i = HIST_DEPTH - 1; i > 0; i--) history[i] <= history[i-1];
        history[0] <= apply_digit;
        if (fill < DEPTH_MAX) fill <= fill + 1'b1;
      end
    end
  end

  // One-deep pending slot for results that arrive while the FSM is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_digit <= '0;
    end else if (!enable) begin
      pend_valid <= 1'b0;
      pend_digit <= '0;
    end else if (to_pending) begin
      pend_valid <= 1'b1;
      pend_digit <= lenet_digit;
    end else if (apply_now && pend_valid) begin
      pend_valid <= 1'b0;
    end
  end

  // Class scan: strictly-greater replacement keeps ties on the lowest class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx   <= '0;
      best_class <= '0;
      best_count <= '0;
    end else if (!enable) begin
      scan_idx   <= '0;
      best_class <= '0;
      best_count <= '0;
    end else if (state == IDLE && scan_req) begin
      scan_idx   <= '0;
      best_class <= '0;
      best_count <= '0;
    end else if (state == SCAN) begin
      if (slot_count > best_count) begin
        best_count <= slot_count;
        best_class <= scan_idx;
      end
      scan_idx <= scan_idx + 1'b1;
    end
  end

  // Published result; a weak majority leaves the previous result in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_digit <= '0;
      stable_valid <= 1'b0;
      votes        <= '0;
    end else if (!enable) begin
      stable_valid <= 1'b0;
      votes        <= '0;
    end else if (state == DECIDE && best_count >= VOTE_MIN) begin
      stable_digit <= best_class;
      stable_valid <= 1'b1;
      votes        <= best_count;
    end
  end

endmodule

// File: tb/tb_lenet_result_voter.sv
// Directed bench for lenet_result_voter at default parameters. A table of
// results with hand-computed outputs is applied in order (history carries
// over between rows), followed by hand-written sequences for latency,
// pending overwrite, enable flush and reset with lenet_ready held high.
module tb_lenet_result_voter;

  localparam int HIST_DEPTH = 5;
  localparam int VOTE_W     = $clog2(HIST_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              lenet_ready;
  logic [3:0]        lenet_digit;
  logic [3:0]        stable_digit;
  logic              stable_valid;
  logic [VOTE_W-1:0] votes;
  logic              busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] digit;
    int         exp_valid;
    int         exp_digit;
    int         exp_votes;
    int         exp_scan;
  } vec_t;

  vec_t vecs [18];
  logic seen;

  lenet_result_voter #(
    .HIST_DEPTH  (5),
    .NUM_CLASSES (10),
    .MIN_VOTES   (3),
    .DIGIT_W     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .lenet_ready  (lenet_ready),
    .lenet_digit  (lenet_digit),
    .stable_digit (stable_digit),
    .stable_valid (stable_valid),
    .votes        (votes),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_output(input string name, input int exp_valid,
                              input int exp_digit, input int exp_votes);
    check_value({name, "_valid"}, int'(stable_valid), exp_valid);
    check_value({name, "_digit"}, int'(stable_digit), exp_digit);
    check_value({name, "_votes"}, int'(votes), exp_votes);
  endtask

  // Drive one ready pulse; returns on the falling edge after the sampling edge
  task automatic apply_stimulus(input logic [3:0] digit);
    @(negedge clk);
    lenet_digit = digit;
    lenet_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lenet_ready = 1'b0;
  endtask

  task automatic watch_busy(input int cycles, output logic busy_seen);
    busy_seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      logic s;
      apply_stimulus(vecs[i].digit);
      watch_busy(15, s);
      check_value($sformatf("row%0d_scan", i), int'(s), vecs[i].exp_scan);
      check_output($sformatf("row%0d", i), vecs[i].exp_valid,
                   vecs[i].exp_digit, vecs[i].exp_votes);
    end
  endtask

  initial begin
    // digit, valid, stable_digit, votes, scan expected
    vecs[0]  = '{4'd1,  0, 0, 0, 1};
    vecs[1]  = '{4'd2,  0, 0, 0, 1};
    vecs[2]  = '{4'd1,  0, 0, 0, 1};
    vecs[3]  = '{4'd2,  0, 0, 0, 1};
    vecs[4]  = '{4'd3,  0, 0, 0, 1};
    vecs[5]  = '{4'd7,  0, 0, 0, 1};
    vecs[6]  = '{4'd7,  0, 0, 0, 1};
    vecs[7]  = '{4'd4,  1, 7, 3, 1};
    vecs[8]  = '{4'd4,  1, 7, 3, 1};
    vecs[9]  = '{4'd9,  1, 7, 3, 1};
    vecs[10] = '{4'd9,  1, 7, 3, 1};
    vecs[11] = '{4'd9,  1, 9, 3, 1};
    vecs[12] = '{4'd9,  1, 9, 4, 1};
    vecs[13] = '{4'd9,  1, 9, 5, 1};
    vecs[14] = '{4'd12, 1, 9, 5, 0};
    vecs[15] = '{4'd3,  1, 9, 4, 1};
    vecs[16] = '{4'd5,  1, 9, 3, 1};
    vecs[17] = '{4'd5,  1, 9, 3, 1};

    rst_n       = 1'b1;
    enable      = 1'b1;
    lenet_ready = 1'b0;
    lenet_digit = 4'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset", 0, 0, 0);
    check_value("reset_busy", int'(busy), 0);
    rst_n = 1'b1;

    $display("[TB] table rows 0-6: weak majorities from reset");
    run_rows(0, 6);

    // Third 7: outputs must move exactly 12 edges after the sampling edge
    $display("[TB] latency of third 7");
    apply_stimulus(4'd7);
    repeat (11) @(posedge clk);
    #1;
    check_output("lat_edge11", 0, 0, 0);
    check_value("lat_edge11_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    check_output("lat_edge12", 1, 7, 3);
    check_value("lat_edge12_busy", int'(busy), 0);

    $display("[TB] table rows 7-17: sliding window and dropped digit");
    run_rows(7, 17);

    // History 5,5,3,9,9; send 1 then 3 and 5 during its scan
    $display("[TB] pending overwrite");
    apply_stimulus(4'd1);
    apply_stimulus(4'd3);
    apply_stimulus(4'd5);
    repeat (11) @(posedge clk);
    #1;
    check_value("pend_second_scan", int'(busy), 1);
    repeat (10) @(posedge clk);
    #1;
    check_output("pend_result", 1, 5, 3);
    check_value("pend_idle", int'(busy), 0);
    watch_busy(20, seen);
    check_value("pend_no_third_scan", int'(seen), 0);

    $display("[TB] enable flush mid-scan");
    apply_stimulus(4'd5);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    watch_busy(15, seen);
    check_value("flush_no_scan", int'(seen), 0);
    check_output("flush", 0, 5, 0);
    apply_stimulus(4'd5);
    watch_busy(15, seen);
    check_output("refill1", 0, 5, 0);
    apply_stimulus(4'd5);
    watch_busy(15, seen);
    check_output("refill2", 0, 5, 0);
    apply_stimulus(4'd5);
    watch_busy(15, seen);
    check_output("refill3", 1, 5, 3);

    $display("[TB] reset with lenet_ready high");
    @(negedge clk);
    lenet_digit = 4'd4;
    lenet_ready = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_output("rst_hold", 0, 0, 0);
    rst_n = 1'b1;
    watch_busy(20, seen);
    check_value("rst_no_spurious", int'(seen), 0);
    check_output("rst_after", 0, 0, 0);
    lenet_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
